// File: rtl/pkt_xmtr.sv
// pkt_xmtr: FIFO-buffered serial transmitter sending each byte as a HEAD + body
// 16-bit frame, MSB first, with an optional idle gap between frames.
module pkt_xmtr #(
   parameter logic [7:0] HEAD  = 8'hA5,
   parameter int         DEPTH = 4,
   parameter int         GAP   = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               data_in,
   input  logic                     writing,
   output logic                     serial_out,
   output logic                     full,
   output logic                     empty,
   output logic                     busy,
   output logic                     dropped,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_HEAD = 2'd1, S_BODY = 2'd2, S_GAP = 2'd3;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [3:0]    gap_cnt;
   logic          wr, pop, body_end, gap_end;
   assign full     = count == CW'(DEPTH);
   assign empty    = count == '0;
   assign busy     = state != S_IDLE;
   assign wr       = writing && !full;
   assign body_end = state == S_BODY && bit_cnt == 3'd0;
   assign gap_end  = state == S_GAP && gap_cnt == 4'd1;
   // a new frame starts from idle, from the last gap clock, or back-to-back when GAP is 0
   assign pop      = !empty && (state == S_IDLE || gap_end || (body_end && GAP == 0));
   always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= data_in;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dropped    <= 1'b0;
         serial_out <= 1'b0;
         state      <= S_IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'd0;
         gap_cnt    <= 4'd0;
      end else begin
         dropped <= writing && full;
         count   <= count + CW'(wr) - CW'(pop);
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + AW'(1);
            shreg      <= mem[rd_ptr];
            serial_out <= HEAD[7];
            bit_cnt    <= 3'd1;
            state      <= S_HEAD;
         end else begin
            case (state)
               S_HEAD: begin
                  serial_out <= bit_cnt == 3'd0 ? shreg[7] : HEAD[3'd7 - bit_cnt];
                  bit_cnt    <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd0) state <= S_BODY;
               end
               S_BODY: begin
                  serial_out <= bit_cnt == 3'd0 ? 1'b0 : shreg[3'd7 - bit_cnt];
                  bit_cnt    <= bit_cnt == 3'd0 ? 3'd0 : bit_cnt + 3'd1;
                  gap_cnt    <= 4'(GAP);
                  if (bit_cnt == 3'd0) state <= GAP == 0 ? S_IDLE : S_GAP;
               end
               S_GAP: begin
                  serial_out <= 1'b0;
                  gap_cnt    <= gap_cnt - 4'd1;
                  if (gap_cnt == 4'd1) state <= S_IDLE;
               end
               default: serial_out <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pkt_xmtr.sv
// tb_pkt_xmtr: drives two transmitters (GAP=0 and GAP=3) with the same writes and
// decodes both serial lines against a queue of expected bytes.
module tb_pkt_xmtr;
   localparam logic [7:0] HEAD = 8'hA5;
   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       writing;
   logic       ser0, full0, empty0, busy0, drop0;
   logic       ser3, full3, empty3, busy3, drop3;
   logic [2:0] cnt0, cnt3;
   int         n_cmp = 0, n_bad = 0, cyc = 0;
   logic [7:0] q0[$], q3[$];
   logic       in_fr[2], b2b[2];
   int         nb[2], last_end[2];
   logic [15:0] sh[2];

   pkt_xmtr #(.HEAD(HEAD), .DEPTH(4), .GAP(0)) u_gap0 (
      .clock(clock), .reset(reset), .data_in(data_in), .writing(writing),
      .serial_out(ser0), .full(full0), .empty(empty0), .busy(busy0),
      .dropped(drop0), .count(cnt0));
   pkt_xmtr #(.HEAD(HEAD), .DEPTH(4), .GAP(3)) u_gap3 (
      .clock(clock), .reset(reset), .data_in(data_in), .writing(writing),
      .serial_out(ser3), .full(full3), .empty(empty3), .busy(busy3),
      .dropped(drop3), .count(cnt3));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // frame decoder: a frame begins on the first 1 after idle, since HEAD[7] is 1
   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         logic s;
         logic [7:0] want;
         s = d == 0 ? ser0 : ser3;
         want = 8'h00;
         if (!reset) begin
            in_fr[d] = 1'b0;
            b2b[d]   = 1'b0;
         end else if (!in_fr[d]) begin
            if (s) begin
               if (b2b[d]) check(d == 0 ? "gap0" : "gap3", cyc - last_end[d] - 1, d == 0 ? 0 : 3);
               in_fr[d] = 1'b1;
               nb[d]    = 1;
               sh[d]    = 16'h0001;
            end
         end else begin
            sh[d] = {sh[d][14:0], s};
            nb[d]++;
            if (nb[d] == 16) begin
               in_fr[d]    = 1'b0;
               last_end[d] = cyc;
               check(d == 0 ? "head0" : "head3", sh[d][15:8], HEAD);
               if (d == 0) begin
                  check("sb0_nonempty", q0.size() != 0, 1);
                  if (q0.size() != 0) want = q0.pop_front();
                  b2b[d] = q0.size() != 0;
               end else begin
                  check("sb3_nonempty", q3.size() != 0, 1);
                  if (q3.size() != 0) want = q3.pop_front();
                  b2b[d] = q3.size() != 0;
               end
               check(d == 0 ? "body0" : "body3", sh[d][7:0], want);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic [7:0] b, input bit acc);
      data_in = b;
      writing = 1'b1;
      step();
      writing = 1'b0;
      if (acc) begin
         q0.push_back(b);
         q3.push_back(b);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || q3.size() != 0 || busy0 || busy3) && t < 2000) begin
         step();
         t++;
      end
      check("drain_timeout", t < 2000, 1);
      check("drain_empty0", empty0, 1);
      check("drain_cnt3", cnt3, 0);
   endtask

   initial begin
      logic [15:0] fr;
      logic [7:0]  msg[6];
      logic [2:0]  exp_cnt[5];
      string       txt;
      reset   = 1'b0;
      writing = 1'b0;
      data_in = 8'h00;
      repeat (2) step();
      check("rst_ser", ser0, 0);
      check("rst_empty", empty0, 1);
      check("rst_full", full0, 0);
      check("rst_busy", busy0, 0);
      check("rst_cnt", cnt0, 0);
      check("rst_drop", drop0, 0);
      reset = 1'b1;
      step();
      // single byte, exact bit sequence and latency
      fr = {HEAD, 8'h49};
      put(8'h49, 1'b1);
      check("t2_cnt", cnt0, 1);
      check("t2_empty_after_write", empty0, 0);
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("t2_bit%0d", i), ser0, fr[15 - i]);
         if (i == 0) check("t2_empty_after_pop", empty0, 1);
      end
      check("t2_busy_last_bit", busy0, 1);
      step();
      check("t2_ser_idle", ser0, 0);
      check("t2_busy_fall", busy0, 0);
      check("t2_busy3_in_gap", busy3, 1);
      repeat (2) step();
      check("t2_busy3_gap_end", busy3, 1);
      step();
      check("t2_busy3_fall", busy3, 0);
      drain();
      // overflow: five accepted, sixth dropped
      msg     = '{8'h49, 8'h20, 8'h4C, 8'h6F, 8'h76, 8'h65};
      exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
      for (int i = 0; i < 5; i++) begin
         put(msg[i], 1'b1);
         check($sformatf("t3_cnt%0d", i), cnt0, exp_cnt[i]);
         check($sformatf("t3_nodrop%0d", i), drop0, 0);
      end
      check("t3_full", full0, 1);
      put(msg[5], 1'b0);
      check("t3_drop0", drop0, 1);
      check("t3_drop3", drop3, 1);
      check("t3_cnt_hold", cnt0, 4);
      step();
      check("t3_drop_pulse", drop0, 0);
      drain();
      // two queued frames: GAP=3 line shows exactly three idle clocks
      put(8'h4C, 1'b1);
      put(8'h6F, 1'b1);
      drain();
      // asynchronous reset in the middle of frame 2
      put(8'h11, 1'b1);
      put(8'h22, 1'b1);
      put(8'h33, 1'b1);
      repeat (27) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("t5_ser", ser0, 0);
      check("t5_cnt", cnt0, 0);
      check("t5_busy", busy0, 0);
      check("t5_empty", empty0, 1);
      check("t5_ser3", ser3, 0);
      check("t5_busy3", busy3, 0);
      q0.delete();
      q3.delete();
      @(negedge clock);
      #1;
      reset = 1'b1;
      step();
      step();
      check("t5_no_resume", ser0, 0);
      check("t5_still_idle", busy0, 0);
      put(8'h56, 1'b1);
      drain();
      // end-to-end message with random write spacing
      txt = "I Love Verilog";
      for (int i = 0; i < txt.len(); i++) begin
         int t = 0;
         repeat ($urandom_range(0, 8)) step();
         while ((full0 || full3) && t < 500) begin
            step();
            t++;
         end
         check("t6_full_timeout", t < 500, 1);
         put(txt[i], 1'b1);
         check("t6_drop0", drop0, 0);
         check("t6_drop3", drop3, 0);
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pkt_xmtr.md
Name: pkt_xmtr

Overview:
Serial packet transmitter that sits directly upstream of the serial packet receiver (rcvr) and drives its 1-bit data input.
- Accepts parallel bytes from a host through a write strobe and buffers them in a small FIFO.
- Serialises each byte as a 16-bit frame: 8-bit header HEAD, then 8 body bits, MSB first, one bit per clock.
- The line idles at 0 between frames.

Parameters:
HEAD, 8'hA5, frame header pattern; must equal the receiver's header
DEPTH, 4, FIFO depth in bytes; power of 2, at least 2
GAP, 0, minimum idle (0) clocks inserted between consecutive frames; range 0..15

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset
data_in  input  8  byte to send; sampled on a posedge where writing=1
writing  input  1  write strobe, one byte per asserted cycle
serial_out  output  1  serial line to receiver data_in
full  output  1  FIFO holds DEPTH bytes
empty  output  1  FIFO holds 0 bytes
busy  output  1  a frame or its trailing gap is on the line
dropped  output  1  one-cycle pulse: a write was rejected because FIFO was full
count  output  $clog2(DEPTH)+1  bytes currently in FIFO

Behaviour:
- Reset (reset=0, asynchronous):
  - serial_out=0, full=0, empty=1, busy=0, dropped=0, count=0.
  - FIFO pointers cleared; FSM to IDLE; shift register and bit counter cleared.
  - Effect is immediate, including mid-frame: the partial frame is abandoned, never resumed, and buffered bytes are discarded.
- All outputs are registered; full, empty and busy are decoded from registered state.
- FIFO write:
  - At a posedge with writing=1 and full=0, data_in is stored and count increments.
  - writing=1 with full=1 drops the byte, count is unchanged, dropped=1 for the next cycle.
  - full is evaluated on the pre-edge count. A write at full is dropped even if a pop occurs on the same edge.
- FIFO pop:
  - Occurs only in IDLE, or at the final cycle of GAP/BODY as below, with empty=0.
  - A simultaneous accepted write and pop leave count unchanged.
- FSM states: IDLE, HEAD, BODY, GAP; 3-bit bit counter bit_cnt.
- IDLE:
  - serial_out=0, busy=0.
  - If empty=0 at the posedge: pop the head byte into the shift register, serial_out<=HEAD[7], bit_cnt<=1, go to HEAD.
- HEAD:
  - Each posedge drives serial_out<=HEAD[7-bit_cnt] and increments bit_cnt.
  - After HEAD[0] has been driven, the next posedge drives body bit 7 and enters BODY with bit_cnt=1.
- BODY:
  - Each posedge drives the next body bit, MSB first.
  - At the posedge after body bit 0 has been driven:
    - GAP=0 and empty=0: pop and drive HEAD[7] of the next frame (HEAD, bit_cnt=1). Frames are contiguous.
    - GAP=0 and empty=1: serial_out<=0, go to IDLE.
    - GAP>0: serial_out<=0, load gap counter, go to GAP.
- GAP:
  - serial_out=0 for exactly GAP clocks, busy=1.
  - Then behaves as IDLE on the final gap edge: pop and start if non-empty, else go to IDLE.
- Latency: a write accepted at edge k into an empty FIFO with FSM in IDLE gives HEAD[7] on serial_out from edge k+1. Body bit 0 is driven from edge k+16.
- busy=1 from the edge driving HEAD[7] until the edge returning to IDLE.
- Body byte value 8'hA5 is transmitted unaltered; no escaping.

Test Plan:
1. Reset: hold reset=0 for 2 clocks -> serial_out=0, empty=1, full=0, busy=0, count=0, dropped=0. Assert reset between edges -> outputs clear without waiting for a clock edge.
2. Single byte: in IDLE, write 8'h49 at edge k (GAP=0).
   - Required serial_out over edges k+1..k+16: 1,0,1,0,0,1,0,1, 0,1,0,0,1,0,0,1.
   - Then serial_out=0, busy falls at edge k+17, empty=1 throughout except after edge k.
3. Overflow (DEPTH=4, GAP=0): write 8'h49,20,4C,6F,76,65 on 6 consecutive edges from idle.
   - count sequence: 1,1,2,3,4; full=1 after the 5th write.
   - 6th byte (8'h65) dropped, with a dropped pulse.
   - Line carries 5 contiguous 16-bit frames (80 bits) with no idle bit, then 0.
4. Gap: GAP=3, two bytes 8'h4C and 8'h6F queued -> exactly 3 zero clocks between the last body bit of frame 1 and HEAD[7] of frame 2.
5. Mid-frame reset: during body bit 3 of the second of three queued frames, pulse reset=0 -> serial_out=0 immediately, count=0, state IDLE.
   - After release, write 8'h56 -> one clean frame A5,56.
6. End-to-end: connect to rcvr; write "I Love Verilog" (14 bytes) with random 0..8-clock gaps between writes, reader servicing ready within 14 clocks.
   - rcvr returns all 14 characters in order; no overrun, no dropped.
